// File: rtl/seg595_scanner.sv
// seg595_scanner: scans eight 8-bit segment patterns onto an 8-digit module
// built from two cascaded 74HC595 shift registers (sclk / rclk / dio).
// Optional build macro SEG595_ACTIVE_LOW_EN inverts the segment byte for
// common-anode modules; the digit-select byte is active-low in both builds.
module seg595_scanner #(
  parameter int unsigned CLK_DIV = 25
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [63:0] seg_data,
  output logic        sclk,
  output logic        rclk,
  output logic        dio,
  output logic        frame_done
);

  localparam int unsigned CntW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam logic [CntW-1:0] CntMax = CntW'(CLK_DIV - 1);

  typedef enum logic [2:0] {
    StIdle,
    StLoad,
    StShLo,
    StShHi,
    StLatch
  } state_e;

  state_e state_q, state_d;

  logic [CntW-1:0] cnt_q;
  logic            tick;

  logic [63:0] frame_q, frame_d;
  logic [15:0] word_q, word_d;
  logic [3:0]  idx_q, idx_d;
  logic [2:0]  digit_q, digit_d;
  logic [7:0]  seg_byte;
  logic [7:0]  sel_byte;

  logic sclk_d, rclk_d, dio_d, frame_done_d;

  assign tick = (cnt_q == CntMax);

  // Scan tick divider: free-running 0..CLK_DIV-1.
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q <= '0;
    end else if (tick) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_q + CntW'(1);
    end
  end

  // FSM state register.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= StIdle;
    end else begin
      state_q <= state_d;
    end
  end

  // FSM next state; every transition waits for a tick.
  always_comb begin
    state_d = state_q;
    if (tick) begin
      case (state_q)
        StIdle:  state_d = StLoad;
        StLoad:  state_d = StShLo;
        StShLo:  state_d = StShHi;
        StShHi:  state_d = (idx_q == 4'd0) ? StLatch : StShLo;
        StLatch: state_d = StLoad;
        default: state_d = StIdle;
      endcase
    end
  end

  // Datapath next state: snapshot, word build, bit index and digit counter.
  always_comb begin
    frame_d  = frame_q;
    word_d   = word_q;
    idx_d    = idx_q;
    digit_d  = digit_q;
    seg_byte = 8'h00;
    sel_byte = 8'hFF;
    if (tick) begin
      case (state_q)
        StLoad: begin
          // Snapshot only at the start of a frame so a frame never tears.
          if (digit_q == 3'd0) begin
            frame_d = seg_data;
          end
`ifdef SEG595_ACTIVE_LOW_EN
          seg_byte = ~frame_d[{digit_q, 3'b000} +: 8];
`else
          seg_byte = frame_d[{digit_q, 3'b000} +: 8];
`endif
          sel_byte = ~(8'b1 << digit_q);
          // Segment byte shifts out first so it ends up in the far 595.
          word_d   = {seg_byte, sel_byte};
          idx_d    = 4'd15;
        end
        StShHi: begin
          if (idx_q != 4'd0) begin
            idx_d = idx_q - 4'd1;
          end
        end
        StLatch: begin
          digit_d = digit_q + 3'd1;
        end
        default: ;
      endcase
    end
  end

  // FSM outputs, decoded from the next state so the pins come straight from flops.
  always_comb begin
    sclk_d       = (state_d == StShHi);
    rclk_d       = (state_d == StLatch);
    dio_d        = 1'b0;
    if ((state_d == StShLo) || (state_d == StShHi)) begin
      dio_d = word_d[idx_d];
    end
    frame_done_d = tick && (state_q == StLatch) && (digit_q == 3'd7);
  end

  // Datapath and output registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      frame_q    <= '0;
      word_q     <= '0;
      idx_q      <= '0;
      digit_q    <= '0;
      sclk       <= 1'b0;
      rclk       <= 1'b0;
      dio        <= 1'b0;
      frame_done <= 1'b0;
    end else begin
      frame_q    <= frame_d;
      word_q     <= word_d;
      idx_q      <= idx_d;
      digit_q    <= digit_d;
      sclk       <= sclk_d;
      rclk       <= rclk_d;
      dio        <= dio_d;
      frame_done <= frame_done_d;
    end
  end

endmodule
